io_handshake_unit: RTL and testbench

- Responder side of the IN/OUT/HALT decode flags from the control unit. Services IN by stalling the single-cycle datapath until the operator presses a debounced enter button, then supplies the switch value for write-back.
- Services OUT by latching a register value into a display holding register.
- On HALT, freezes the datapath until reset.
- Sits between the control unit / register file and the board I/O (switches, button, 7-segment driver).

---
 rtl/io_handshake_unit.sv | 124 ++++++++++++
 tb/tb_io_handshake_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/io_handshake_unit.sv
// Responder for IN/OUT/HALT: stalls the datapath on IN until a debounced
// enter press, latches OUT values for the display, and freezes on HALT.
module io_handshake_unit #(
  parameter int DATA_W          = 32,
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              input_flag,
  input  logic              output_flag,
  input  logic              halt,
  input  logic [DATA_W-1:0] out_data,
  input  logic [SW_W-1:0]   switches,
  input  logic              enter_btn,
  output logic              stall,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic [DATA_W-1:0] out_reg,
  output logic              out_valid,
  output logic              halted
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_PRESS = 2'd1;
  localparam logic [1:0] HALTED     = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]        state_reg;
  logic              sync1_reg;
  logic              sync_reg;
  logic              db_reg;
  logic              db_q_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] in_data_reg;
  logic              in_valid_reg;
  logic [DATA_W-1:0] out_reg_reg;
  logic              out_valid_reg;
  logic              press_evt;

  // Button path: two-flop synchronizer followed by a stable-level counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_reg <= 1'b0;
      sync_reg  <= 1'b0;
      db_reg    <= 1'b0;
      db_q_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= enter_btn;
      sync_reg  <= sync1_reg;
      db_q_reg  <= db_reg;
      if (sync_reg == db_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        db_reg  <= sync_reg;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign press_evt = db_reg & ~db_q_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= IDLE;
      in_data_reg   <= '0;
      in_valid_reg  <= 1'b0;
      out_reg_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      in_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // in_valid marks the commit cycle of the current IN; don't re-arm on it.
          if (halt) begin
            state_reg <= HALTED;
          end else if (input_flag && !in_valid_reg) begin
            state_reg <= WAIT_PRESS;
          end else if (output_flag && !input_flag) begin
            out_reg_reg   <= out_data;
            out_valid_reg <= 1'b1;
          end
        end
        WAIT_PRESS: begin
          if (press_evt) begin
            in_data_reg  <= DATA_W'(switches);
            in_valid_reg <= 1'b1;
            state_reg    <= IDLE;
          end
        end
        HALTED: begin
          state_reg <= HALTED;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Held low during reset so the datapath is never frozen by stale state.
  always_comb begin
    stall = 1'b0;
    if (reset) begin
      stall = ((state_reg == IDLE) & input_flag & ~in_valid_reg & ~halt)
            | (state_reg == WAIT_PRESS)
            | (state_reg == HALTED)
            | ((state_reg == IDLE) & halt);
    end
  end

  assign in_data   = in_data_reg;
  assign in_valid  = in_valid_reg;
  assign out_reg   = out_reg_reg;
  assign out_valid = out_valid_reg;
  assign halted    = (state_reg == HALTED);

endmodule

// File: tb/tb_io_handshake_unit.sv
// Self-checking bench for io_handshake_unit with DEBOUNCE_CYCLES=4: per-cycle
// vectors check stall/in_valid/halted, scoreboards check captured words.
module tb_io_handshake_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        input_flag = 1'b0;
  logic        output_flag = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] out_data = '0;
  logic [15:0] switches = '0;
  logic        enter_btn = 1'b0;
  logic        stall;
  logic [31:0] in_data;
  logic        in_valid;
  logic [31:0] out_reg;
  logic        out_valid;
  logic        halted;

  always #5 clock = ~clock;

  io_handshake_unit #(
    .DATA_W(32), .SW_W(16), .DEBOUNCE_CYCLES(4), .CNT_W(5)
  ) dut (
    .clock(clock), .reset(reset), .input_flag(input_flag),
    .output_flag(output_flag), .halt(halt), .out_data(out_data),
    .switches(switches), .enter_btn(enter_btn), .stall(stall),
    .in_data(in_data), .in_valid(in_valid), .out_reg(out_reg),
    .out_valid(out_valid), .halted(halted)
  );

  typedef struct {
    logic        inf, outf, hl, btn;
    logic [31:0] od;
    logic [15:0] sw;
    logic        e_stall, e_iv, e_halted;
    logic        push_in, push_out;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] out_q[$];
  logic [31:0] in_q[$];
  vec_t        tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic inf, outf, hl, btn, input logic [31:0] od,
                              input logic [15:0] sw, input logic e_stall, e_iv,
                              e_halted, push_in, push_out);
    vec_t v;
    v.inf = inf; v.outf = outf; v.hl = hl; v.btn = btn; v.od = od; v.sw = sw;
    v.e_stall = e_stall; v.e_iv = e_iv; v.e_halted = e_halted;
    v.push_in = push_in; v.push_out = push_out;
    return v;
  endfunction

  // Entered 1ns after a rising edge; drives one cycle, samples on the falling edge.
  task automatic step(input vec_t v, input string name);
    logic [31:0] exp_word;
    input_flag = v.inf; output_flag = v.outf; halt = v.hl; enter_btn = v.btn;
    out_data = v.od; switches = v.sw;
    if (v.push_out) out_q.push_back(v.od);
    if (v.push_in) in_q.push_back({16'h0000, v.sw});
    #4;
    chk({name, " stall"}, {31'd0, stall}, {31'd0, v.e_stall});
    chk({name, " in_valid"}, {31'd0, in_valid}, {31'd0, v.e_iv});
    chk({name, " halted"}, {31'd0, halted}, {31'd0, v.e_halted});
    if (out_valid) begin
      if (out_q.size() == 0) chk({name, " unexpected out_valid"}, {31'd0, out_valid}, 32'd0);
      else begin
        exp_word = out_q.pop_front();
        chk({name, " out_reg"}, out_reg, exp_word);
      end
    end
    if (in_valid) begin
      if (in_q.size() == 0) chk({name, " unexpected in_valid"}, {31'd0, in_valid}, 32'd0);
      else begin
        exp_word = in_q.pop_front();
        chk({name, " in_data"}, in_data, exp_word);
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Press from a settled low button: db rises after 6 edges, capture one edge later.
  task automatic press_capture(input logic outf, input logic [15:0] sw, input string name);
    for (int i = 0; i < 7; i++)
      step(mk(1, outf, 0, (i < 6), 0, sw, 1, 0, 0, 0, 0), {name, " wait"});
    step(mk(1, outf, 0, 0, 0, sw, 0, 1, 0, 0, 0), {name, " commit"});
  endtask

  task automatic repeat_step(input int n, input logic inf, btn, e_stall, input logic [15:0] sw,
                             input string name);
    for (int i = 0; i < n; i++)
      step(mk(inf, 0, 0, btn, 0, sw, e_stall, 0, 0, 0, 0), name);
  endtask

  initial begin
    @(posedge clock);
    #1;
    // Reset with random flags: stall must stay low and registers clear.
    for (int i = 0; i < 2; i++) begin
      input_flag = 1'($urandom_range(0, 1));
      output_flag = 1'($urandom_range(0, 1));
      halt = 1'($urandom_range(0, 1));
      out_data = $urandom;
      #4;
      chk("reset stall", {31'd0, stall}, 32'd0);
      if (i == 1) begin
        chk("reset in_valid", {31'd0, in_valid}, 32'd0);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_reg", out_reg, 32'd0);
        chk("reset in_data", in_data, 32'd0);
        chk("reset halted", {31'd0, halted}, 32'd0);
      end
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_reset");

    // OUT vectors: single, back-to-back, then idle.
    tbl.push_back(mk(0, 1, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h11111111, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h22222222, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h33333333, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("out_vec%0d", i));

    // Clean IN.
    step(mk(1, 0, 0, 0, 0, 16'hA5A5, 1, 0, 0, 1, 0), "in1 issue");
    repeat_step(2, 1, 0, 1, 16'hA5A5, "in1 idle_wait");
    press_capture(0, 16'hA5A5, "in1");
    // Back-to-back IN: re-arms the cycle after in_valid, needs release + new press.
    step(mk(1, 0, 0, 0, 0, 16'h5A5A, 1, 0, 0, 1, 0), "in2 issue");
    repeat_step(8, 1, 0, 1, 16'h5A5A, "in2 release");
    press_capture(0, 16'h5A5A, "in2");
    repeat_step(4, 0, 0, 0, 16'h0, "settle1");

    // Glitch of 3 cycles must not capture; a 6-cycle press must.
    step(mk(1, 0, 0, 0, 0, 16'h0F0F, 1, 0, 0, 1, 0), "glitch issue");
    repeat_step(3, 1, 1, 1, 16'h0F0F, "glitch high");
    repeat_step(6, 1, 0, 1, 16'h0F0F, "glitch low");
    press_capture(0, 16'h0F0F, "glitch press");
    repeat_step(4, 0, 0, 0, 16'h0, "settle2");

    // Button already held when IN issues: only release + re-press completes it.
    repeat_step(8, 0, 1, 0, 16'h0, "held idle");
    step(mk(1, 0, 0, 1, 0, 16'hBEEF, 1, 0, 0, 1, 0), "held issue");
    repeat_step(6, 1, 1, 1, 16'hBEEF, "held high");
    repeat_step(8, 1, 0, 1, 16'hBEEF, "held release");
    press_capture(0, 16'hBEEF, "held press");
    repeat_step(4, 0, 0, 0, 16'h0, "settle3");

    // Simultaneous IN and OUT: treated as IN, display untouched.
    step(mk(1, 1, 0, 0, 32'hCAFEF00D, 16'h1234, 1, 0, 0, 1, 0), "both issue");
    repeat_step(2, 1, 0, 1, 16'h1234, "both wait");
    press_capture(1, 16'h1234, "both");
    repeat_step(2, 0, 0, 0, 16'h0, "both settle");
    chk("both out_reg kept", out_reg, 32'h33333333);
    chk("in_data held", in_data, 32'h00001234);

    // HALT is absorbing regardless of flags and button.
    step(mk(1, 1, 1, 0, 32'h12345678, 16'h4321, 1, 0, 0, 0, 0), "halt issue");
    for (int i = 0; i < 8; i++)
      step(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom, 16'($urandom), 1, 0, 1, 0, 0),
           $sformatf("halted%0d", i));
    reset = 1'b0;
    input_flag = 0; output_flag = 0; halt = 0; enter_btn = 0;
    #4;
    chk("halt reset stall", {31'd0, stall}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "after halt reset");

    chk("out scoreboard drained", out_q.size(), 32'd0);
    chk("in scoreboard drained", in_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
